// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared encodings and defaults for the two-requester memory bus arbiter
//   SZ_BYTE/SZ_HALF/SZ_WORD : transfer-size encodings carried on *_size
//   SZ_W                    : width of the size field in a buffered request
//   ERR_DATA_DEF            : default read data returned when a read times out
//   op_e                    : kind of a buffered request
//   rr_pick                 : round-robin winner between two pending requesters
package mem_bus_pkg;

   localparam int SZ_W = 2;

   localparam logic [SZ_W-1:0] SZ_BYTE = 2'd0;
   localparam logic [SZ_W-1:0] SZ_HALF = 2'd1;
   localparam logic [SZ_W-1:0] SZ_WORD = 2'd2;

   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   // With both pending the one that did not win last time goes; otherwise the only pending one.
   function automatic logic rr_pick(input logic p0, input logic p1, input logic last);
      return (p0 & p1) ? ~last : p1;
   endfunction

endpackage

// File: rtl/mem_req_slot.sv
// mem_req_slot: one-deep request buffer for a single requester
//   clk, rst_n      : clock, asynchronous active-low reset
//   rd_en, wr_en    : request strobes from the requester (read wins if both high)
//   addr, wr_data   : request address and write data
//   size            : request transfer size
//   hold            : this requester owns the outstanding read
//   clr             : the buffered request is being issued on this edge
//   busy            : requester may not issue (buffer full or read in flight)
//   pend            : a request is buffered
//   req_op, req_addr, req_data, req_size : buffered request
module mem_req_slot
   import mem_bus_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rd_en,
   input  logic            wr_en,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   wr_data,
   input  logic [SZ_W-1:0] size,
   input  logic            hold,
   input  logic            clr,
   output logic            busy,
   output logic            pend,
   output op_e             req_op,
   output logic [AW-1:0]   req_addr,
   output logic [DW-1:0]   req_data,
   output logic [SZ_W-1:0] req_size
);

   logic cap;

   // busy depends on registered state only, so there is no input-to-busy path
   assign busy = pend | hold;
   assign cap  = (rd_en | wr_en) & ~busy;

   // cap and clr never coincide: clr needs pend, and pend forces busy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend     <= 1'b0;
         req_op   <= OP_RD;
         req_addr <= '0;
         req_data <= '0;
         req_size <= '0;
      end else if (cap) begin
         pend     <= 1'b1;
         req_op   <= rd_en ? OP_RD : OP_WR;
         req_addr <= addr;
         req_data <= wr_data;
         req_size <= size;
      end else if (clr) begin
         pend     <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter of two requesters onto a single-port memory bus
//   clk, rst_n          : clock, asynchronous active-low reset
//   m0_* / m1_*         : requester ports (rd_en, wr_en, addr, wr_data, size in;
//                         rd_data, rd_vld, busy out); requester 0 is the core data port
//   s_rd_en, s_wr_en    : slave strobes, valid for the cycle the request issues
//   s_addr, s_wr_data, s_size : slave payload (zero when nothing issues)
//   s_rd_data, s_rd_vld : slave read return
//   s_busy              : slave cannot accept this cycle
//   to_err              : one-cycle pulse when an outstanding read times out
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int             AW       = 32,
   parameter int             DW       = 32,
   parameter int             TO_CYC   = 255,
   parameter logic [DW-1:0]  ERR_DATA = DW'(ERR_DATA_DEF)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            m0_rd_en,
   input  logic            m0_wr_en,
   input  logic [AW-1:0]   m0_addr,
   input  logic [DW-1:0]   m0_wr_data,
   input  logic [SZ_W-1:0] m0_size,
   output logic [DW-1:0]   m0_rd_data,
   output logic            m0_rd_vld,
   output logic            m0_busy,
   input  logic            m1_rd_en,
   input  logic            m1_wr_en,
   input  logic [AW-1:0]   m1_addr,
   input  logic [DW-1:0]   m1_wr_data,
   input  logic [SZ_W-1:0] m1_size,
   output logic [DW-1:0]   m1_rd_data,
   output logic            m1_rd_vld,
   output logic            m1_busy,
   output logic            s_rd_en,
   output logic            s_wr_en,
   output logic [AW-1:0]   s_addr,
   output logic [DW-1:0]   s_wr_data,
   output logic [SZ_W-1:0] s_size,
   input  logic [DW-1:0]   s_rd_data,
   input  logic            s_rd_vld,
   input  logic            s_busy,
   output logic            to_err
);

   localparam int CW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

   logic [1:0]      pend;
   logic [1:0]      hold;
   logic [1:0]      clr;
   op_e             req_op   [2];
   logic [AW-1:0]   req_addr [2];
   logic [DW-1:0]   req_data [2];
   logic [SZ_W-1:0] req_size [2];

   logic            rd_out;
   logic            owner;
   logic            last_grant;
   logic [CW-1:0]   cnt;

   logic            issue;
   logic            win;
   logic            wr_sel;
   logic            rd_hit;
   logic            to_hit;
   logic            rsp_vld;
   logic [DW-1:0]   rsp_data;

   assign hold = {rd_out & owner, rd_out & ~owner};
   assign clr  = {issue & win, issue & ~win};

   mem_req_slot #(.AW(AW), .DW(DW)) u_slot0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (m0_rd_en),
      .wr_en    (m0_wr_en),
      .addr     (m0_addr),
      .wr_data  (m0_wr_data),
      .size     (m0_size),
      .hold     (hold[0]),
      .clr      (clr[0]),
      .busy     (m0_busy),
      .pend     (pend[0]),
      .req_op   (req_op[0]),
      .req_addr (req_addr[0]),
      .req_data (req_data[0]),
      .req_size (req_size[0])
   );

   mem_req_slot #(.AW(AW), .DW(DW)) u_slot1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (m1_rd_en),
      .wr_en    (m1_wr_en),
      .addr     (m1_addr),
      .wr_data  (m1_wr_data),
      .size     (m1_size),
      .hold     (hold[1]),
      .clr      (clr[1]),
      .busy     (m1_busy),
      .pend     (pend[1]),
      .req_op   (req_op[1]),
      .req_addr (req_addr[1]),
      .req_data (req_data[1]),
      .req_size (req_size[1])
   );

   // Nothing issues while a read is outstanding, which keeps slave ordering trivial.
   assign issue  = (|pend) & ~rd_out & ~s_busy;
   assign win    = rr_pick(pend[0], pend[1], last_grant);
   assign wr_sel = req_op[win] == OP_WR;

   assign s_rd_en   = issue & ~wr_sel;
   assign s_wr_en   = issue & wr_sel;
   assign s_addr    = issue ? req_addr[win] : '0;
   assign s_wr_data = issue ? req_data[win] : '0;
   assign s_size    = issue ? req_size[win] : '0;

   // A real response in the expiry cycle beats the timeout; responses with no read in flight are dropped.
   assign rd_hit   = rd_out & s_rd_vld;
   assign to_hit   = (TO_CYC != 0) & rd_out & ~s_rd_vld & (cnt == CW'(TO_CYC - 1));
   assign rsp_vld  = rd_hit | to_hit;
   assign rsp_data = rd_hit ? s_rd_data : ERR_DATA;

   assign m0_rd_vld  = rsp_vld & ~owner;
   assign m1_rd_vld  = rsp_vld & owner;
   assign m0_rd_data = m0_rd_vld ? rsp_data : '0;
   assign m1_rd_data = m1_rd_vld ? rsp_data : '0;
   assign to_err     = to_hit;

   // last_grant resets to 1 so requester 0 wins the first contention
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_out     <= 1'b0;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         cnt        <= '0;
      end else if (issue) begin
         last_grant <= win;
         if (!wr_sel) begin
            rd_out <= 1'b1;
            owner  <= win;
            cnt    <= '0;
         end
      end else if (rsp_vld) begin
         rd_out <= 1'b0;
      end else if (rd_out) begin
         cnt    <= cnt + 1'b1;
      end
   end

endmodule
